// File: rtl/seq_mul32.sv
// seq_mul32: iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional macro SEQ_MUL_EARLY_TERM_EN skips iterations once the remaining multiplier bits are zero.
`default_nettype none

module cla_adder32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;
  logic [8:0]  w_gc;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = cin;

  // 4-bit lookahead groups, group carries rippled between groups
  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    localparam int B = gi * 4;
    assign w_c[B]   = w_gc[gi];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    assign w_gc[gi+1] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
  end

  assign w_c[32] = w_gc[8];
  assign sum     = w_p ^ w_c[31:0];
  assign cout    = w_c[32];
endmodule

module seq_mul32 #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             r_neg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  logic             w_sa;
  logic             w_sb;
  logic [31:0]      w_sum;
  logic             w_carry;
  logic [63:0]      w_neg64;
  logic             w_rem_zero;
  logic [63:0]      w_early;

  assign w_sa = rs1[31] & ((op == 2'd1) | (op == 2'd2));
  assign w_sb = rs2[31] & (op == 2'd1);

  cla_adder32b u_add (
    .a    (r_hi),
    .b    (r_mcand),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_carry)
  );

  assign w_neg64 = ~{r_hi, r_lo} + 64'd1;

`ifdef SEQ_MUL_EARLY_TERM_EN
  logic [31:0] w_mask;
  logic [5:0]  w_shamt;
  // Multiplier bits still to be consumed sit in lo[31-cnt:0]
  assign w_mask     = 32'hFFFF_FFFF >> r_cnt;
  assign w_rem_zero = ((r_lo & w_mask) == 32'd0);
  assign w_shamt    = 6'd32 - {1'b0, r_cnt};
  assign w_early    = {r_hi, r_lo} >> w_shamt;
`else
  assign w_rem_zero = 1'b0;
  assign w_early    = 64'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 2'd0;
      r_mcand     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= op;
            r_mcand <= w_sa ? (~rs1 + 32'd1) : rs1;
            r_lo    <= w_sb ? (~rs2 + 32'd1) : rs2;
            r_hi    <= '0;
            r_neg   <= w_sa ^ w_sb;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_rem_zero) begin
            {r_hi, r_lo} <= w_early;
            r_state      <= S_FIX;
          end else begin
            if (r_lo[0]) begin
              {r_hi, r_lo} <= {w_carry, w_sum, r_lo[31:1]};
            end else begin
              {r_hi, r_lo} <= {1'b0, r_hi, r_lo[31:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == 5'd31) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (r_neg) begin
            {r_hi, r_lo} <= w_neg64;
          end
          r_state <= S_DONE;
        end
        default: begin
          // Output register stage: valid is raised one edge after entering DONE
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUSY) | (r_state == S_FIX);
  assign out_valid = r_out_valid;
  assign result    = r_out_valid ? ((r_op == 2'd0) ? r_lo : r_hi) : 32'd0;
endmodule

`default_nettype wire
